led_breather: RTL and testbench



---
 rtl/led_breather_pkg.sv | 19 +
 rtl/led_breather_pwm.sv | 35 +++
 rtl/led_breather.sv | 116 +++++++++++
 tb/tb_led_breather.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/led_breather_pkg.sv
// Shared constants and state encoding for the LED breathing envelope.
package led_breather_pkg;

  localparam int LED_W            = 8;
  localparam int DEF_PWM_BITS     = 8;
  localparam int DEF_STEP_DIV     = 4;
  localparam int DEF_HOLD_PERIODS = 16;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RISE    = 3'd1;
  localparam logic [2:0] ST_HOLD_HI = 3'd2;
  localparam logic [2:0] ST_FALL    = 3'd3;
  localparam logic [2:0] ST_HOLD_LO = 3'd4;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_breather_pwm.sv
// Free-running PWM counter, wrap/period tick and the gated LED register.
module led_breather_pwm
  import led_breather_pkg::*;
#(
  parameter int PWM_BITS = DEF_PWM_BITS
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] level,
  input  logic [LED_W-1:0]    pattern_q,
  output logic                wrap,
  output logic                period_tick,
  output logic [LED_W-1:0]    led
);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic                lit;

  assign wrap = enable && (pwm_cnt == '1);
  assign lit  = pwm_cnt < level;

  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      pwm_cnt     <= '0;
      period_tick <= 1'b0;
      led         <= '0;
    end else begin
      pwm_cnt     <= pwm_cnt + PWM_BITS'(1);
      period_tick <= wrap;
      led         <= pattern_q & {LED_W{lit}};
    end
  end

endmodule

// File: rtl/led_breather.sv
// Breathing envelope FSM: ramps PWM brightness up, holds, ramps down, holds.
module led_breather
  import led_breather_pkg::*;
#(
  parameter int PWM_BITS     = DEF_PWM_BITS,
  parameter int STEP_DIV     = DEF_STEP_DIV,
  parameter int HOLD_PERIODS = DEF_HOLD_PERIODS
) (
  input  logic [1:0]          clock_reset,
  input  logic                enable,
  input  logic [LED_W-1:0]    pattern,
  output logic [LED_W-1:0]    led,
  output logic [PWM_BITS-1:0] level,
  output logic                period_tick
);

  localparam int SW = cnt_w(STEP_DIV);
  localparam int HW = cnt_w(HOLD_PERIODS);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_PERIODS - 1);

  logic                clock;
  logic                reset;
  logic                wrap;
  logic [2:0]          state;
  logic [SW-1:0]       step_cnt;
  logic [HW-1:0]       hold_cnt;
  logic [LED_W-1:0]    pattern_q;
  logic [PWM_BITS-1:0] lvl_up;
  logic [PWM_BITS-1:0] lvl_dn;
  logic                step_done;
  logic                hold_done;

  assign clock     = clock_reset[0];
  assign reset     = clock_reset[1];
  assign lvl_up    = level + PWM_BITS'(1);
  assign lvl_dn    = level - PWM_BITS'(1);
  assign step_done = step_cnt == STEP_LAST;
  assign hold_done = hold_cnt == HOLD_LAST;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      level     <= '0;
      step_cnt  <= '0;
      hold_cnt  <= '0;
      pattern_q <= '0;
    end else if (!enable) begin
      state    <= ST_IDLE;
      level    <= '0;
      step_cnt <= '0;
      hold_cnt <= '0;
    end else if (wrap) begin
      pattern_q <= pattern;
      unique case (state)
        ST_IDLE: state <= ST_RISE;
        ST_RISE: begin
          if (step_done) begin
            step_cnt <= '0;
            level    <= lvl_up;
            // limit check on the post-step value
            if (lvl_up == '1) begin
              state    <= ST_HOLD_HI;
              hold_cnt <= '0;
            end
          end else begin
            step_cnt <= step_cnt + SW'(1);
          end
        end
        ST_HOLD_HI: begin
          if (hold_done) begin
            hold_cnt <= '0;
            state    <= ST_FALL;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        ST_FALL: begin
          if (step_done) begin
            step_cnt <= '0;
            level    <= lvl_dn;
            if (lvl_dn == '0) begin
              state    <= ST_HOLD_LO;
              hold_cnt <= '0;
            end
          end else begin
            step_cnt <= step_cnt + SW'(1);
          end
        end
        ST_HOLD_LO: begin
          if (hold_done) begin
            hold_cnt <= '0;
            state    <= ST_RISE;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  led_breather_pwm #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .level       (level),
    .pattern_q   (pattern_q),
    .wrap        (wrap),
    .period_tick (period_tick),
    .led         (led)
  );

endmodule

// File: tb/tb_led_breather.sv
// Scoreboard bench: two parameterisations, random stimulus, envelope model.
module tb_led_breather;

  localparam int PA = 4, SA = 1, HA = 2;
  localparam int PB = 3, SB = 3, HB = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic [7:0]    pat = 8'h00;
  logic [1:0]    cr;
  logic [7:0]    led_a, led_b;
  logic [PA-1:0] lvl_a;
  logic [PB-1:0] lvl_b;
  logic          tick_a, tick_b;

  assign cr = {rst, clk};

  led_breather #(
    .PWM_BITS(PA), .STEP_DIV(SA), .HOLD_PERIODS(HA)
  ) dut_a (
    .clock_reset(cr), .enable(en), .pattern(pat),
    .led(led_a), .level(lvl_a), .period_tick(tick_a)
  );

  led_breather #(
    .PWM_BITS(PB), .STEP_DIV(SB), .HOLD_PERIODS(HB)
  ) dut_b (
    .clock_reset(cr), .enable(en), .pattern(pat),
    .led(led_b), .level(lvl_b), .period_tick(tick_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] led_a;
    int         lvl_a;
    bit         tick_a;
    logic [7:0] led_b;
    int         lvl_b;
    bit         tick_b;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  int   ea = 0, eb = 0;
  logic [7:0] pqa = 8'h00, pqb = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // brightness after k enabled wraps, from the envelope shape
  function automatic int ref_level(input int k, input int p,
                                   input int s, input int h);
    int mx, ms, b, m;
    if (k == 0) return 0;
    mx = (1 << p) - 1;
    ms = mx * s;
    b  = 2 * ms + 2 * h;
    m  = (k - 1) % b;
    if (m < ms) return m / s;
    if (m < ms + h) return mx;
    if (m < 2 * ms + h) return mx - (m - ms - h) / s;
    return 0;
  endfunction

  task automatic model(input bit r, input bit e_in,
                       input logic [7:0] pt,
                       input int p, input int s, input int h,
                       inout int e, inout logic [7:0] pq,
                       output logic [7:0] ld, output int lv,
                       output bit tk);
    int n, c;
    n = 1 << p;
    if (r) begin
      e = 0; pq = 8'h00; ld = 8'h00; lv = 0; tk = 1'b0;
    end else if (!e_in) begin
      e = 0; ld = 8'h00; lv = 0; tk = 1'b0;
    end else begin
      c  = e % n;
      ld = (c < ref_level(e / n, p, s, h)) ? pq : 8'h00;
      tk = (c == n - 1);
      if (tk) pq = pt;
      e  = e + 1;
      lv = ref_level(e / n, p, s, h);
    end
  endtask

  task automatic drive(input bit r, input bit e_in, input logic [7:0] pt);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r;
    en  = e_in;
    pat = pt;
    x.cyc = cyc + 1;
    model(r, e_in, pt, PA, SA, HA, ea, pqa, x.led_a, x.lvl_a, x.tick_a);
    model(r, e_in, pt, PB, SB, HB, eb, pqb, x.led_b, x.lvl_b, x.tick_b);
    q.push_back(x);
  endtask

  task automatic chk(input string nm, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h",
               nm, cyc, act, req);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #3;
      while (q.size() > 0 && q[0].cyc < cyc) begin
        tests++;
        fails++;
        $display("FAIL missed cyc=%0d actual=none expected=%0d",
                 cyc, q[0].cyc);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        x = q.pop_front();
        chk("led_a",  int'(led_a),  int'(x.led_a));
        chk("lvl_a",  int'(lvl_a),  x.lvl_a);
        chk("tick_a", int'(tick_a), int'(x.tick_a));
        chk("led_b",  int'(led_b),  int'(x.led_b));
        chk("lvl_b",  int'(lvl_b),  x.lvl_b);
        chk("tick_b", int'(tick_b), int'(x.tick_b));
      end
    end
  end

  initial begin : stim
    logic [7:0] p;
    bit         r, e;
    int         dis, w;
    repeat (3) drive(1'b1, 1'b0, 8'h00);
    repeat (600) drive(1'b0, 1'b0, 8'($urandom));
    p = 8'hAA;
    repeat (800) begin
      if ($urandom_range(39) == 0)
        p = ($urandom_range(1) == 1) ? 8'hAA : 8'h55;
      drive(1'b0, 1'b1, p);
    end
    dis = 0;
    repeat (4000) begin
      r = ($urandom_range(1499) == 0);
      if (dis == 0 && $urandom_range(799) == 0)
        dis = $urandom_range(5, 1);
      e = (dis == 0);
      if (dis > 0) dis--;
      if ($urandom_range(29) == 0) p = 8'($urandom);
      drive(r, e, p);
    end
    repeat (3) drive(1'b0, 1'b0, 8'h00);
    w = 0;
    while (q.size() > 0 && w < 10) begin
      @(posedge clk);
      w++;
    end
    #5;
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain actual=%0d expected=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
